writeback_checker: RTL and testbench
====================================

WRITEBACK_CHECKER -- requirements
Module: writeback_checker

Interface
REQ-001 Parameter DATA_W, default 32: width of register data, expected values and the cycle counter.
REQ-002 Parameter NUM_REGS, default 8: number of consecutive architectural registers checked.
REQ-003 Parameter BASE_REG, default 8: index of the first checked register ($t0).
REQ-004 Parameter CHECK_CYCLE, default 14: run cycle on which checking starts in MODE 0.
REQ-005 Parameter MODE, default 0: 0 = check at fixed cycle; 1 = check once every tracked register has been written, with a timeout.
REQ-006 Parameter MAX_CYCLES, default 1000: MODE 1 timeout in run cycles.
REQ-007 clk  in  1  single clock; every register updates on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 start  in  1  one-cycle pulse that begins a run.
REQ-010 exp_wr_en  in  1  loads one expected value.
REQ-011 exp_idx  in  clog2(NUM_REGS)  slot of the expected value, relative to BASE_REG.
REQ-012 exp_data  in  DATA_W  expected value.
REQ-013 wb_en  in  1  writeback-stage register-file write enable (snooped).
REQ-014 wb_addr  in  5  writeback destination register.
REQ-015 wb_data  in  DATA_W  writeback data.
REQ-016 busy  out  1  high in RUN and CHECK.
REQ-017 done  out  1  high in DONE.
REQ-018 pass  out  1  valid when done; 1 = no mismatches and no timeout.
REQ-019 timeout  out  1  MODE 1 run ended by MAX_CYCLES.
REQ-020 mismatch_cnt  out  clog2(NUM_REGS+1)  number of slots that failed comparison.
REQ-021 first_bad_idx  out  clog2(NUM_REGS)  lowest failing slot; 0 when there are no failures.
REQ-022 cycle_cnt  out  DATA_W  run cycles elapsed.

Function
REQ-023 States: IDLE, RUN, CHECK, DONE; reset state is IDLE.
REQ-024 exp_wr_en writes the expected array in IDLE and DONE only; it is ignored in RUN and CHECK.
REQ-025 start in IDLE or DONE: enter RUN, clear cycle_cnt, shadow valid bits, mismatch_cnt, first_bad_idx and timeout; the expected array is retained; start in RUN or CHECK is ignored.
REQ-026 RUN: cycle_cnt increments by 1 each cycle, starting from 1 on the first RUN edge; saturates at all-ones.
REQ-027 RUN: wb_en with BASE_REG <= wb_addr < BASE_REG+NUM_REGS and wb_addr != 0 stores wb_data in shadow slot wb_addr-BASE_REG and sets its valid bit; the last write to a slot wins.
REQ-028 MODE 0: on the edge where cycle_cnt becomes CHECK_CYCLE, go to CHECK; a snooped write on that same edge is captured.
REQ-029 MODE 1: go to CHECK on the edge after all valid bits are set; if cycle_cnt reaches MAX_CYCLES first, set timeout and go to CHECK.
REQ-030 CHECK: compare one slot per cycle, in order 0..NUM_REGS-1; this takes exactly NUM_REGS cycles, then go to DONE.
REQ-031 A slot fails when its valid bit is 0 or shadow != expected; each failure increments mismatch_cnt, and the first failure records first_bad_idx.
REQ-032 cycle_cnt is frozen in CHECK and DONE.
REQ-033 DONE: done=1 and pass=(mismatch_cnt==0 && !timeout), held until start or rst.

Reset
REQ-034 rst takes priority over every other input and returns to IDLE from any state, including mid-RUN and mid-CHECK.
REQ-035 On rst, all outputs become 0 and all valid bits are cleared.
REQ-036 The expected and shadow data arrays are not reset.

Verification
REQ-037 MODE 0, defaults: load expected 4,8,...,32; start; write $8..$15 = 4,8,...,32 by cycle 10 -> CHECK entered at cycle_cnt=14, done 8 cycles later, pass=1, mismatch_cnt=0, cycle_cnt=14.
REQ-038 As REQ-037 but $10=13 and $13 never written -> pass=0, mismatch_cnt=2, first_bad_idx=2.
REQ-039 Write to $15 on the edge where cycle_cnt becomes 14 -> the write is captured and pass=1; the same write one cycle later -> slot 7 fails.
REQ-040 MODE 1, MAX_CYCLES=20: all 8 slots written by cycle 9 -> CHECK entered at cycle 10, pass=1; omit $9 -> timeout=1 at cycle_cnt=20, mismatch_cnt=1, first_bad_idx=1.
REQ-041 rst asserted during CHECK -> IDLE and all outputs 0 on the next edge; a new start with the expected values reloaded -> correct pass.
REQ-042 Writes to $0, $7 and $16, exp_wr_en during RUN, and start during RUN -> no effect on shadow, expected array or state.

Source files
------------

// File: rtl/writeback_checker_if.sv
// Handshake and result bundle for writeback_checker: run control, expected-value
// loading, snooped writeback port and the checker's results.
interface writeback_checker_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 8
) ();
    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_REGS + 1);

    logic              start;
    logic              exp_wr_en;
    logic [IDX_W-1:0]  exp_idx;
    logic [DATA_W-1:0] exp_data;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [CNT_W-1:0]  mismatch_cnt;
    logic [IDX_W-1:0]  first_bad_idx;
    logic [DATA_W-1:0] cycle_cnt;

    modport master (
        output start, exp_wr_en, exp_idx, exp_data, wb_en, wb_addr, wb_data,
        input  busy, done, pass, timeout, mismatch_cnt, first_bad_idx, cycle_cnt
    );

    modport slave (
        input  start, exp_wr_en, exp_idx, exp_data, wb_en, wb_addr, wb_data,
        output busy, done, pass, timeout, mismatch_cnt, first_bad_idx, cycle_cnt
    );
endinterface

// File: rtl/writeback_checker.sv
// Writeback checker: snoops register-file writes into a shadow copy of a window
// of architectural registers during a run, then compares the shadow copy with a
// preloaded expected array one slot per cycle and reports pass/fail.
module writeback_checker #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned BASE_REG    = 8,
    parameter int unsigned CHECK_CYCLE = 14,
    parameter int unsigned MODE        = 0,
    parameter int unsigned MAX_CYCLES  = 1000
) (
    input  logic               clk,
    input  logic               rst,
    writeback_checker_if.slave bus
);
    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned CNT_W  = $clog2(NUM_REGS + 1);
    localparam int unsigned REG_LO = BASE_REG;
    localparam int unsigned REG_HI = BASE_REG + NUM_REGS;
    localparam logic [DATA_W-1:0] CYCLE_SAT = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CHECK,
        DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] exp_mem    [NUM_REGS];
    logic [DATA_W-1:0] shadow_mem [NUM_REGS];
    logic [NUM_REGS-1:0] valid;
    logic [IDX_W-1:0]  chk_idx;

    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              timeout_q;
    logic [CNT_W-1:0]  mismatch_q;
    logic [IDX_W-1:0]  first_bad_q;
    logic [DATA_W-1:0] cycle_q;

    logic [DATA_W-1:0] cycle_inc;
    logic              wb_hit;
    logic [IDX_W-1:0]  wb_slot;
    logic              exp_hit;
    logic              slot_bad;
    logic              last_slot;

    // Saturating run-cycle increment.
    assign cycle_inc = (cycle_q == CYCLE_SAT) ? cycle_q : cycle_q + DATA_W'(1);

    // Snooped write lands in the tracked window ($0 is never tracked).
    assign wb_hit  = bus.wb_en && (bus.wb_addr != 5'd0)
                  && (32'(bus.wb_addr) >= REG_LO) && (32'(bus.wb_addr) < REG_HI);
    assign wb_slot = IDX_W'(32'(bus.wb_addr) - REG_LO);

    // Expected values may only change while no run is in flight.
    assign exp_hit = bus.exp_wr_en && (32'(bus.exp_idx) < NUM_REGS)
                  && ((state == IDLE) || (state == DONE));

    // Current slot under comparison fails if never written or wrong.
    assign slot_bad  = !valid[chk_idx] || (shadow_mem[chk_idx] != exp_mem[chk_idx]);
    assign last_slot = (32'(chk_idx) == NUM_REGS - 1);

    // Data arrays: no reset, writes blocked while rst is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (exp_hit) begin
                exp_mem[bus.exp_idx] <= bus.exp_data;
            end
            if ((state == RUN) && wb_hit) begin
                shadow_mem[wb_slot] <= bus.wb_data;
            end
        end
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            valid       <= '0;
            chk_idx     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            mismatch_q  <= '0;
            first_bad_q <= '0;
            cycle_q     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state       <= RUN;
                        valid       <= '0;
                        chk_idx     <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                        mismatch_q  <= '0;
                        first_bad_q <= '0;
                        cycle_q     <= '0;
                    end
                end

                RUN: begin
                    cycle_q <= cycle_inc;
                    if (wb_hit) begin
                        valid[wb_slot] <= 1'b1;
                    end
                    if (MODE == 0) begin
                        if (cycle_inc == DATA_W'(CHECK_CYCLE)) begin
                            state   <= CHECK;
                            chk_idx <= '0;
                        end
                    end else begin
                        // All-written decision uses the valid bits from before this edge.
                        if (&valid) begin
                            state   <= CHECK;
                            chk_idx <= '0;
                        end else if (cycle_inc == DATA_W'(MAX_CYCLES)) begin
                            timeout_q <= 1'b1;
                            state     <= CHECK;
                            chk_idx   <= '0;
                        end
                    end
                end

                CHECK: begin
                    if (slot_bad) begin
                        mismatch_q <= mismatch_q + CNT_W'(1);
                        if (mismatch_q == '0) begin
                            first_bad_q <= chk_idx;
                        end
                    end
                    if (last_slot) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= !slot_bad && (mismatch_q == '0) && !timeout_q;
                    end else begin
                        chk_idx <= chk_idx + IDX_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Drive the result bundle from the registered state.
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.timeout       = timeout_q;
    assign bus.mismatch_cnt  = mismatch_q;
    assign bus.first_bad_idx = first_bad_q;
    assign bus.cycle_cnt     = cycle_q;
endmodule

// File: tb/tb_writeback_checker.sv
// Bench for writeback_checker: one fixed-cycle instance and one all-written /
// timeout instance share the same stimulus; a behavioural model per instance
// predicts every output each cycle, and directed runs pin literal results.
`timescale 1ns/1ps
module tb_writeback_checker;
    localparam int CHK  = 14;
    localparam int MAXC = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start, exp_wr_en, wb_en;
    logic [2:0]  exp_idx;
    logic [31:0] exp_data, wb_data;
    logic [4:0]  wb_addr;

    writeback_checker_if #(.DATA_W(32), .NUM_REGS(8)) bus0 ();
    writeback_checker_if #(.DATA_W(32), .NUM_REGS(8)) bus1 ();

    assign bus0.start = start;     assign bus1.start = start;
    assign bus0.exp_wr_en = exp_wr_en; assign bus1.exp_wr_en = exp_wr_en;
    assign bus0.exp_idx = exp_idx; assign bus1.exp_idx = exp_idx;
    assign bus0.exp_data = exp_data; assign bus1.exp_data = exp_data;
    assign bus0.wb_en = wb_en;     assign bus1.wb_en = wb_en;
    assign bus0.wb_addr = wb_addr; assign bus1.wb_addr = wb_addr;
    assign bus0.wb_data = wb_data; assign bus1.wb_data = wb_data;

    writeback_checker #(.MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    writeback_checker #(.MODE(1), .MAX_CYCLES(MAXC)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [1:0]  g_busy, g_done, g_pass, g_to;
    logic [3:0]  g_mm  [2];
    logic [2:0]  g_fb  [2];
    logic [31:0] g_cyc [2];
    assign g_busy = {bus1.busy, bus0.busy};
    assign g_done = {bus1.done, bus0.done};
    assign g_pass = {bus1.pass, bus0.pass};
    assign g_to   = {bus1.timeout, bus0.timeout};
    assign g_mm[0] = bus0.mismatch_cnt;  assign g_mm[1] = bus1.mismatch_cnt;
    assign g_fb[0] = bus0.first_bad_idx; assign g_fb[1] = bus1.first_bad_idx;
    assign g_cyc[0] = bus0.cycle_cnt;    assign g_cyc[1] = bus1.cycle_cnt;

    int total = 0;
    int bad   = 0;
    int nprint = 0;
    bit cmp_en = 1'b0;

    task automatic cmp(input string nm, input int m, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            if (nprint < 60) begin
                nprint++;
                $display("FAIL %s dut%0d: got %0d, want %0d (t=%0t)", nm, m, got, want, $time);
            end
        end
    endtask

    // Behavioural model: phase 0 idle, 1 running, 2 comparing, 3 finished.
    int          mph  [2];
    longint      mcyc [2];
    bit          mto  [2];
    int          mk   [2];      // slots compared so far
    bit [7:0]    mfail[2];      // failing slots, fixed when comparing begins
    bit [7:0]    mval [2];
    bit [31:0]   mexp [2][8];
    bit [31:0]   msh  [2][8];

    task automatic model_step(input int m);
        bit allv;
        bit go;
        int slot;
        if (rst) begin
            mph[m] = 0; mval[m] = '0; mcyc[m] = 0; mto[m] = 0; mk[m] = 0; mfail[m] = '0;
            return;
        end
        case (mph[m])
            0, 3: begin
                if (exp_wr_en) mexp[m][exp_idx] = exp_data;
                if (start) begin
                    mph[m] = 1; mcyc[m] = 0; mval[m] = '0; mto[m] = 0; mk[m] = 0; mfail[m] = '0;
                end
            end
            1: begin
                allv = (mval[m] == 8'hFF);
                if (mcyc[m] < 64'hFFFF_FFFF) mcyc[m] = mcyc[m] + 1;
                if (wb_en && wb_addr >= 8 && wb_addr < 16) begin
                    slot = int'(wb_addr) - 8;
                    msh[m][slot] = wb_data;
                    mval[m][slot] = 1'b1;
                end
                go = 1'b0;
                if (m == 0) go = (mcyc[m] == CHK);
                else if (allv) go = 1'b1;
                else if (mcyc[m] == MAXC) begin mto[m] = 1'b1; go = 1'b1; end
                if (go) begin
                    mph[m] = 2; mk[m] = 0;
                    for (int i = 0; i < 8; i++)
                        mfail[m][i] = !mval[m][i] || (msh[m][i] != mexp[m][i]);
                end
            end
            2: begin
                mk[m] = mk[m] + 1;
                if (mk[m] == 8) mph[m] = 3;
            end
            default: mph[m] = 0;
        endcase
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int m = 0; m < 2; m++) begin
                int em;
                int efb;
                bit found;
                em = 0; efb = 0; found = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    if (i < mk[m] && mfail[m][i]) begin
                        em++;
                        if (!found) begin efb = i; found = 1'b1; end
                    end
                end
                cmp("busy", m, g_busy[m], (mph[m] == 1 || mph[m] == 2) ? 1 : 0);
                cmp("done", m, g_done[m], (mph[m] == 3) ? 1 : 0);
                cmp("pass", m, g_pass[m], (mph[m] == 3 && mfail[m] == 0 && !mto[m]) ? 1 : 0);
                cmp("timeout", m, g_to[m], mto[m]);
                cmp("mismatch_cnt", m, g_mm[m], em);
                cmp("first_bad_idx", m, g_fb[m], efb);
                cmp("cycle_cnt", m, g_cyc[m], mcyc[m]);
            end
        end
    end

    int dir_data[8];
    int dir_at[8];

    task automatic set_dir(input int dbase, input int dstep, input int abase);
        for (int i = 0; i < 8; i++) begin
            dir_data[i] = dbase + dstep * i;
            dir_at[i]   = abase + i;
        end
    endtask

    task automatic load_exp(input int base, input int step);
        for (int i = 0; i < 8; i++) begin
            exp_wr_en = 1'b1; exp_idx = 3'(i); exp_data = 32'(base + step * i);
            @(negedge clk);
        end
        exp_wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drive edges 1..k after the call; slot i written on edge dir_at[i].
    task automatic directed_run(input int k);
        for (int e = 1; e <= k; e++) begin
            wb_en = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (dir_at[i] == e) begin
                    wb_en = 1'b1; wb_addr = 5'(8 + i); wb_data = 32'(dir_data[i]);
                end
            end
            @(negedge clk);
        end
        wb_en = 1'b0;
    endtask

    task automatic wait_done(input int m, input int bound, output int n);
        n = 0;
        while (!g_done[m] && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!g_done[m]) cmp("wait_done_timeout", m, 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n1;
        rst = 1'b1; start = 1'b0; exp_wr_en = 1'b0; exp_idx = '0; exp_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        @(negedge clk); @(negedge clk);
        cmp_en = 1'b1;
        for (int m = 0; m < 2; m++) begin
            cmp("rst_busy", m, g_busy[m], 0);
            cmp("rst_done", m, g_done[m], 0);
            cmp("rst_cyc", m, g_cyc[m], 0);
        end
        rst = 1'b0;

        // Clean fixed-cycle run.
        load_exp(4, 4);
        set_dir(4, 4, 3);
        pulse_start();
        directed_run(10);
        wait_done(0, 40, n);
        cmp("r037_done_edge", 0, 10 + n, 22);
        cmp("r037_pass", 0, g_pass[0], 1);
        cmp("r037_mm", 0, g_mm[0], 0);
        cmp("r037_cyc", 0, g_cyc[0], 14);
        cmp("r037_model_cyc", 0, mcyc[0], 14);
        wait_done(1, 40, n1);

        // Wrong value in $10 and $13 never written.
        set_dir(4, 4, 3);
        dir_data[2] = 13; dir_at[5] = 0;
        pulse_start();
        directed_run(10);
        wait_done(0, 40, n);
        cmp("r038_pass", 0, g_pass[0], 0);
        cmp("r038_mm", 0, g_mm[0], 2);
        cmp("r038_fb", 0, g_fb[0], 2);
        wait_done(1, 40, n1);

        // $15 on the edge where cycle_cnt becomes 14 is captured.
        set_dir(4, 4, 3);
        dir_at[7] = 14;
        pulse_start();
        directed_run(14);
        wait_done(0, 40, n);
        cmp("r039a_done_edge", 0, 14 + n, 22);
        cmp("r039a_pass", 0, g_pass[0], 1);
        wait_done(1, 40, n1);

        // One cycle later it misses.
        dir_at[7] = 15;
        pulse_start();
        directed_run(15);
        wait_done(0, 40, n);
        cmp("r039b_pass", 0, g_pass[0], 0);
        cmp("r039b_mm", 0, g_mm[0], 1);
        cmp("r039b_fb", 0, g_fb[0], 7);
        wait_done(1, 40, n1);

        // All-written instance: complete by cycle 9.
        set_dir(4, 4, 2);
        pulse_start();
        directed_run(9);
        wait_done(1, 40, n1);
        cmp("r040a_done_edge", 1, 9 + n1, 18);
        cmp("r040a_cyc", 1, g_cyc[1], 10);
        cmp("r040a_pass", 1, g_pass[1], 1);
        cmp("r040a_to", 1, g_to[1], 0);
        wait_done(0, 40, n);

        // $9 omitted: timeout.
        set_dir(4, 4, 2);
        dir_at[1] = 0;
        pulse_start();
        directed_run(9);
        wait_done(1, 40, n1);
        cmp("r040b_to", 1, g_to[1], 1);
        cmp("r040b_cyc", 1, g_cyc[1], 20);
        cmp("r040b_mm", 1, g_mm[1], 1);
        cmp("r040b_fb", 1, g_fb[1], 1);
        cmp("r040b_pass", 1, g_pass[1], 0);
        cmp("r040b_model_to", 1, mto[1], 1);
        wait_done(0, 40, n);

        // Reset during CHECK, after a failure was already counted.
        set_dir(4, 4, 3);
        dir_data[0] = 1;
        pulse_start();
        directed_run(16);
        cmp("r041_mm_before", 0, g_mm[0], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmp("r041_busy", 0, g_busy[0], 0);
        cmp("r041_done", 0, g_done[0], 0);
        cmp("r041_pass", 0, g_pass[0], 0);
        cmp("r041_to", 0, g_to[0], 0);
        cmp("r041_mm", 0, g_mm[0], 0);
        cmp("r041_fb", 0, g_fb[0], 0);
        cmp("r041_cyc", 0, g_cyc[0], 0);
        load_exp(100, 3);
        set_dir(100, 3, 3);
        pulse_start();
        directed_run(10);
        wait_done(0, 40, n);
        cmp("r041_rerun_pass", 0, g_pass[0], 1);
        wait_done(1, 40, n1);

        // Out-of-window writes, exp_wr_en and start during RUN are ignored.
        pulse_start();
        wb_en = 1'b1; wb_addr = 5'd0;  wb_data = 32'd7;  @(negedge clk);
        wb_addr = 5'd7;  wb_data = 32'd8;  @(negedge clk);
        wb_addr = 5'd16; wb_data = 32'd9;  @(negedge clk);
        wb_en = 1'b0;
        exp_wr_en = 1'b1; exp_idx = 3'd0; exp_data = 32'd999; @(negedge clk);
        exp_wr_en = 1'b0;
        start = 1'b1; @(negedge clk);
        start = 1'b0;
        set_dir(100, 3, 1);
        directed_run(8);
        wait_done(0, 40, n);
        cmp("r042_done_edge", 0, 13 + n, 22);
        cmp("r042_pass", 0, g_pass[0], 1);
        cmp("r042_cyc", 0, g_cyc[0], 14);
        wait_done(1, 40, n1);

        // Randomized runs checked by the model.
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    exp_wr_en = 1'b1; exp_idx = 3'(i); exp_data = 32'($urandom_range(0, 15));
                    @(negedge clk);
                end
            end
            exp_wr_en = 1'b0;
            pulse_start();
            n = 0;
            while ((mph[0] == 1 || mph[0] == 2 || mph[1] == 1 || mph[1] == 2) && n < 80) begin
                wb_en = ($urandom_range(0, 9) < 6);
                if ($urandom_range(0, 4) != 0) wb_addr = 5'(8 + $urandom_range(0, 7));
                else wb_addr = 5'($urandom_range(0, 31));
                if (wb_addr >= 8 && wb_addr < 16 && $urandom_range(0, 6) != 0)
                    wb_data = mexp[0][int'(wb_addr) - 8];
                else
                    wb_data = 32'($urandom_range(0, 15));
                exp_wr_en = ($urandom_range(0, 9) == 0);
                exp_idx   = 3'($urandom_range(0, 7));
                exp_data  = 32'($urandom_range(0, 15));
                start     = ($urandom_range(0, 19) == 0);
                rst       = ($urandom_range(0, 49) == 0);
                @(negedge clk);
                n++;
            end
            wb_en = 1'b0; exp_wr_en = 1'b0; start = 1'b0; rst = 1'b0;
            if (n >= 80) cmp("random_run_bound", r, 0, 1);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
